fmv_frame_queue: RTL and testbench

Display-side frame scheduler for the FMV path, sitting directly upstream of the frame player. It tracks which DDR frame buffers hold fully decoded YUV 4:2:0 pictures, queues them in decode order, and paces their presentation against the display vblank using a fractional rate accumulator. At the selected vblank it drives the frame player's `frame_adr` and `latch_frame` inputs, and it returns the previously shown buffer to the decoder for reuse.

---
 rtl/fmv_frame_queue_if.sv | 44 ++++
 rtl/fmv_frame_queue.sv | 193 +++++++++++++++++++
 tb/tb_fmv_frame_queue.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmv_frame_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fmv_frame_queue_if
// Description : Handshake/bus bundle between the FMV decoder/display side and
//               the frame scheduler (fmv_frame_queue).
//               master : drives decoder completions, vblank and controls,
//                        observes the display address and buffer releases.
//               slave  : the scheduler itself.
// Signals     : frame_done/frame_done_buf  decoded-buffer completion pulse
//               vblank, play, flush, rate_step  pacing controls
//               frame_adr, latch_frame          frame player controls
//               buf_free, buf_free_idx          buffer release pulse
//               free_mask, queue_level, underrun_cnt, proto_err  status
// Revision    : 1.0 - initial release
// ============================================================================
interface fmv_frame_queue_if;
    logic        frame_done;
    logic [1:0]  frame_done_buf;
    logic        vblank;
    logic        play;
    logic        flush;
    logic [16:0] rate_step;
    logic [28:0] frame_adr;
    logic        latch_frame;
    logic        buf_free;
    logic [1:0]  buf_free_idx;
    logic [3:0]  free_mask;
    logic [2:0]  queue_level;
    logic [7:0]  underrun_cnt;
    logic        proto_err;

    modport master (
        output frame_done, frame_done_buf, vblank, play, flush, rate_step,
        input  frame_adr, latch_frame, buf_free, buf_free_idx,
               free_mask, queue_level, underrun_cnt, proto_err
    );

    modport slave (
        input  frame_done, frame_done_buf, vblank, play, flush, rate_step,
        output frame_adr, latch_frame, buf_free, buf_free_idx,
               free_mask, queue_level, underrun_cnt, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/fmv_frame_queue.sv
`default_nettype none
// ============================================================================
// Module      : fmv_frame_queue
// Description : Display-side frame scheduler. Queues decoded frame buffers in
//               decode order, paces presentation against vblank with a 16-bit
//               fractional rate accumulator, drives the frame player address
//               and latch, and hands the previously shown buffer back to the
//               decoder.
// Ports       : clk    - pixel-side clock
//               reset  - synchronous, active-high
//               bus    - fmv_frame_queue_if.slave (controls in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module fmv_frame_queue #(
    parameter int          NUM_BUFS     = 4,
    parameter logic [28:0] FRAME_BASE   = 29'h0,
    parameter logic [28:0] FRAME_STRIDE = 29'h21000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fmv_frame_queue_if.slave   bus
);

    localparam int c_IDX_W = 2;
    localparam int c_LVL_W = $clog2(NUM_BUFS + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0]  r_fifo [NUM_BUFS];
    logic [c_IDX_W-1:0]  r_rd_ptr;
    logic [c_IDX_W-1:0]  r_wr_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_disp_valid;
    logic [c_IDX_W-1:0]  r_disp_idx;
    logic [15:0]         r_acc;
    logic                r_vblank_q;
    logic [28:0]         r_frame_adr;
    logic                r_latch_frame;
    logic                r_buf_free;
    logic [c_IDX_W-1:0]  r_buf_free_idx;
    logic [NUM_BUFS-1:0] r_free_mask;
    logic [7:0]          r_underrun_cnt;
    logic                r_proto_err;

    // ------------------------------------------------------------------------
    // Field pacing
    // ------------------------------------------------------------------------
    logic                w_tick;
    logic [17:0]         w_sum;
    logic                w_advance;
    logic                w_empty;
    logic                w_pop;
    logic                w_underrun;
    logic                w_release;
    logic [c_IDX_W-1:0]  w_head;
    logic [28:0]         w_head_adr;

    assign w_tick     = bus.play & bus.vblank & ~r_vblank_q;
    assign w_sum      = {2'b00, r_acc} + {1'b0, bus.rate_step};
    assign w_advance  = w_tick & (w_sum[17:16] != 2'b00);
    assign w_empty    = (r_level == '0);
    assign w_pop      = w_advance & ~w_empty;
    assign w_underrun = w_advance & w_empty;
    assign w_release  = w_pop & r_disp_valid;
    assign w_head     = r_fifo[r_rd_ptr];
    // Product is kept to 29 bits; any overflow is discarded.
    assign w_head_adr = FRAME_BASE + (29'(w_head) * FRAME_STRIDE);

    // ------------------------------------------------------------------------
    // Buffer ownership, push acceptance and queue bookkeeping
    // ------------------------------------------------------------------------
    logic [NUM_BUFS-1:0] w_head_1h;
    logic [NUM_BUFS-1:0] w_disp_1h;
    logic [NUM_BUFS-1:0] w_push_1h;
    logic [NUM_BUFS-1:0] w_flushed;
    logic [NUM_BUFS-1:0] w_avail;
    logic [NUM_BUFS-1:0] w_mask_next;
    logic                w_push_ok;
    logic                w_push_bad;
    logic [c_IDX_W-1:0]  w_rd_next;
    logic [c_IDX_W-1:0]  w_wr_base;
    logic [c_LVL_W-1:0]  w_level_base;
    logic [c_LVL_W-1:0]  w_level_next;

    always_comb begin
        w_head_1h = '0;
        w_disp_1h = '0;
        w_push_1h = '0;
        w_head_1h[w_head] = 1'b1;
        if (r_disp_valid) begin
            w_disp_1h[r_disp_idx] = 1'b1;
        end
        w_push_1h[bus.frame_done_buf] = 1'b1;

        // Non-free buffers are either queued or displayed. A flush frees the
        // queued ones, except a head popped this same cycle, which becomes
        // the displayed frame. The buffer being released this cycle is not
        // yet available for a push.
        w_flushed = '0;
        if (bus.flush) begin
            w_flushed = ~r_free_mask & ~w_disp_1h & ~(w_pop ? w_head_1h : '0);
        end
        w_avail = r_free_mask | w_flushed;

        w_push_ok  = bus.frame_done & (|(w_avail & w_push_1h));
        w_push_bad = bus.frame_done & ~(|(w_avail & w_push_1h));

        w_mask_next = (w_avail & ~(w_push_ok ? w_push_1h : '0))
                    | (w_release ? w_disp_1h : '0);

        // Pop uses the pre-cycle queue; flush then clears the remainder, and
        // a simultaneous push lands in the (possibly just emptied) queue.
        w_rd_next    = bus.flush ? '0 : r_rd_ptr + c_IDX_W'(w_pop);
        w_wr_base    = bus.flush ? '0 : r_wr_ptr;
        w_level_base = bus.flush ? '0 : r_level - c_LVL_W'(w_pop);
        w_level_next = w_level_base + c_LVL_W'(w_push_ok);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                r_fifo[i] <= '0;
            end
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_level        <= '0;
            r_disp_valid   <= 1'b0;
            r_disp_idx     <= '0;
            r_acc          <= '0;
            r_vblank_q     <= 1'b0;
            r_frame_adr    <= FRAME_BASE;
            r_latch_frame  <= 1'b0;
            r_buf_free     <= 1'b0;
            r_buf_free_idx <= '0;
            r_free_mask    <= '1;
            r_underrun_cnt <= '0;
            r_proto_err    <= 1'b0;
        end else begin
            r_vblank_q    <= bus.vblank;
            r_latch_frame <= w_pop;
            r_buf_free    <= w_release;

            if (w_tick) begin
                r_acc <= w_sum[15:0];
            end

            if (w_pop) begin
                r_frame_adr  <= w_head_adr;
                r_disp_idx   <= w_head;
                r_disp_valid <= 1'b1;
            end

            if (w_release) begin
                r_buf_free_idx <= r_disp_idx;
            end

            if (w_push_ok) begin
                r_fifo[w_wr_base] <= bus.frame_done_buf;
            end

            r_rd_ptr    <= w_rd_next;
            r_wr_ptr    <= w_wr_base + c_IDX_W'(w_push_ok);
            r_level     <= w_level_next;
            r_free_mask <= w_mask_next;

            if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end

            if (w_push_bad) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.frame_adr    = r_frame_adr;
    assign bus.latch_frame  = r_latch_frame;
    assign bus.buf_free     = r_buf_free;
    assign bus.buf_free_idx = r_buf_free_idx;
    assign bus.free_mask    = r_free_mask;
    assign bus.queue_level  = 3'(r_level);
    assign bus.underrun_cnt = r_underrun_cnt;
    assign bus.proto_err    = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fmv_frame_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmv_frame_queue
// Description : Self-checking bench for fmv_frame_queue. A queue-based
//               reference model predicts every output after each clock;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmv_frame_queue;

    localparam logic [28:0] c_BASE   = 29'h0;
    localparam logic [28:0] c_STRIDE = 29'h21000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fmv_frame_queue_if bus ();

    fmv_frame_queue #(
        .NUM_BUFS     (4),
        .FRAME_BASE   (c_BASE),
        .FRAME_STRIDE (c_STRIDE)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a plain queue of buffer indices plus displayed buffer
    // ------------------------------------------------------------------------
    int          m_q[$];
    bit          m_dv;
    int          m_di;
    int          m_acc;
    bit          m_prev_vb;
    int          m_urun;
    bit          m_perr;
    logic [28:0] m_adr;
    bit          m_latch;
    bit          m_bf;
    int          m_bfi;

    int g_play = 1;
    int g_rate = 65536;
    bit last_latch;
    bit last_bf;

    function automatic logic [28:0] adr_of(input int i);
        longint a;
        a = (longint'(c_BASE) + longint'(i) * longint'(c_STRIDE)) % (64'd1 << 29);
        return 29'(a);
    endfunction

    function automatic bit in_q(input int b);
        foreach (m_q[k]) if (m_q[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++)
            m[i] = !(in_q(i) || (m_dv && m_di == i));
        return m;
    endfunction

    task automatic m_step(input bit r, input bit fd, input int fdb, input bit vb,
                          input bit pl, input bit fl, input int rs);
        bit tick;
        int sum;
        int released;
        int h;
        if (r) begin
            m_q.delete();
            m_dv = 0; m_di = 0; m_acc = 0; m_prev_vb = 0; m_urun = 0; m_perr = 0;
            m_adr = c_BASE; m_latch = 0; m_bf = 0; m_bfi = 0;
            return;
        end
        tick      = pl && vb && !m_prev_vb;
        m_prev_vb = vb;
        m_latch   = 0;
        m_bf      = 0;
        released  = -1;
        if (tick) begin
            sum   = m_acc + rs;
            m_acc = sum % 65536;
            if (sum >= 65536) begin
                if (m_q.size() > 0) begin
                    h       = m_q.pop_front();
                    m_latch = 1;
                    m_adr   = adr_of(h);
                    if (m_dv) begin
                        m_bf     = 1;
                        m_bfi    = m_di;
                        released = m_di;
                    end
                    m_di = h;
                    m_dv = 1;
                end else if (m_urun < 255) begin
                    m_urun++;
                end
            end
        end
        if (fl) m_q.delete();
        if (fd) begin
            if (in_q(fdb) || (m_dv && m_di == fdb) || released == fdb) m_perr = 1;
            else m_q.push_back(fdb);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic cyc(input bit r, input bit fd, input int fdb, input bit vb, input bit fl);
        rst                = r;
        bus.frame_done     = fd;
        bus.frame_done_buf = 2'(fdb);
        bus.vblank         = vb;
        bus.play           = (g_play != 0);
        bus.flush          = fl;
        bus.rate_step      = 17'(g_rate);
        m_step(r, fd, fdb, vb, g_play != 0, fl, g_rate);
        @(posedge clk);
        #1;
        check("frame_adr",    32'(bus.frame_adr),    32'(m_adr));
        check("latch_frame",  32'(bus.latch_frame),  32'(m_latch));
        check("buf_free",     32'(bus.buf_free),     32'(m_bf));
        if (m_bf || r) check("buf_free_idx", 32'(bus.buf_free_idx), 32'(m_bfi));
        check("free_mask",    32'(bus.free_mask),    32'(exp_mask()));
        check("queue_level",  32'(bus.queue_level),  32'(m_q.size()));
        check("underrun_cnt", 32'(bus.underrun_cnt), 32'(m_urun));
        check("proto_err",    32'(bus.proto_err),    32'(m_perr));
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic push(input int b);
        cyc(0, 1, b, 0, 0);
    endtask

    // Two low cycles, one rising vblank cycle (the tick), one more high cycle.
    task automatic field();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        last_latch = bus.latch_frame;
        last_bf    = bus.buf_free;
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic fill_free();
        for (int b = 0; b < 4; b++)
            if (!in_q(b) && !(m_dv && m_di == b)) push(b);
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin : main
        int latches;
        int u0;
        int rates[5] = '{65536, 32768, 21845, 131071, 40000};

        // Reset values
        do_reset();
        check("rst_adr",   32'(bus.frame_adr),    32'(c_BASE));
        check("rst_mask",  32'(bus.free_mask),    32'hF);
        check("rst_level", 32'(bus.queue_level),  32'd0);
        check("rst_urun",  32'(bus.underrun_cnt), 32'd0);

        // Basic display sequence
        g_rate = 65536; g_play = 1;
        push(0); push(1); push(2);
        field();
        check("v1_latch", 32'(last_latch),   32'd1);
        check("v1_adr",   32'(bus.frame_adr), 32'h0);
        field();
        check("v2_adr",   32'(bus.frame_adr), 32'h21000);
        check("v2_free",  32'(last_bf),       32'd1);
        check("v2_fidx",  32'(bus.buf_free_idx), 32'd0);
        check("v2_mask",  32'(bus.free_mask), 32'b1001);

        // Half rate with the queue kept full
        g_rate  = 32768;
        latches = 0;
        for (int f = 0; f < 10; f++) begin
            fill_free();
            field();
            latches += last_latch;
            check("half_pattern", 32'(last_latch), 32'(f % 2));
        end
        check("half_count", 32'(latches), 32'd5);

        // Underrun counting and saturation
        do_reset();
        g_rate  = 65536;
        latches = 0;
        for (int f = 0; f < 3; f++) begin
            field();
            latches += last_latch;
        end
        check("urun3",       32'(bus.underrun_cnt), 32'd3);
        check("urun3_latch", 32'(latches),          32'd0);
        for (int f = 0; f < 257; f++) field();
        check("urun_sat", 32'(bus.underrun_cnt), 32'd255);

        // Flush keeps the displayed frame
        do_reset();
        push(0);
        field();
        push(1); push(3);
        cyc(0, 0, 0, 0, 1);
        check("flush_level", 32'(bus.queue_level), 32'd0);
        check("flush_mask",  32'(bus.free_mask),   32'b1110);
        u0 = bus.underrun_cnt;
        field();
        check("flush_urun",  32'(bus.underrun_cnt), 32'(u0 + 1));
        check("flush_adr",   32'(bus.frame_adr),    32'h0);
        check("flush_latch", 32'(last_latch),       32'd0);

        // Double push is a protocol error
        do_reset();
        push(2); push(2);
        check("dup_err",   32'(bus.proto_err),   32'd1);
        check("dup_level", 32'(bus.queue_level), 32'd1);

        // Pause holds the accumulator
        do_reset();
        push(0); push(1); push(2); push(3);
        g_rate = 32768;
        field();
        check("pause_pre", 32'(last_latch), 32'd0);
        g_play  = 0;
        latches = 0;
        for (int f = 0; f < 5; f++) begin
            field();
            latches += last_latch;
        end
        check("pause_nolatch", 32'(latches),         32'd0);
        check("pause_level",   32'(bus.queue_level), 32'd4);
        g_play = 1;
        field();
        check("pause_resume", 32'(last_latch), 32'd1);

        // Same-cycle corner cases
        do_reset();
        g_rate = 65536;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);               // push into empty queue during an underrun
        check("pp_level", 32'(bus.queue_level), 32'd1);
        cyc(0, 0, 0, 0, 0);
        push(2);
        cyc(0, 1, 3, 1, 1);               // advance + flush + push
        check("afp_level", 32'(bus.queue_level), 32'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);               // push of the buffer released this cycle
        check("rel_err", 32'(bus.proto_err), 32'd1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) g_rate = rates[$urandom_range(0, 4)];
            if ($urandom_range(0, 29) == 0) g_play = ($urandom_range(0, 7) != 0);
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
